evo_xb_csr_arb: RTL

Round-robin arbiter and sequencer that shares the OpenEvo XB CSR register space between multiple bus requesters (AVR core bridge, host/debug bridge, DMA-style engines). Each requester issues single-beat read or write transactions; the block serialises them onto one CSR strobe interface, enforces the XB address window (at or above 12'h800, clear of the BSP space) and returns per-requester ack/err pulses with read data.

---
 rtl/evo_xb_csr_arb.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/evo_xb_csr_arb.sv
// evo_xb_csr_arb: round-robin arbiter that serialises single-beat CSR
// reads and writes from NUM_REQ requesters onto one CSR strobe interface.
// Accesses below XB_BASE are rejected with an err pulse and never reach
// the CSR bus.
// Optional feature macro: EVO_XB_ARB_TIMEOUT_EN. When defined, an access
// is aborted with err after TIMEOUT cycles without csr_ack. When it is
// undefined, an access waits for csr_ack indefinitely.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no transaction; pick round-robin winner, latch its request
// S_ACCESS | csr_sel high, waiting for csr_ack (or timeout when enabled)
// S_RESP   | ack pulse to the served requester, rdata valid
// S_ERR    | err pulse to the served requester (window violation/timeout)

module evo_xb_csr_arb #(
    parameter int                NUM_REQ = 2,
    parameter int                ADDR_W  = 12,
    parameter int                DATA_W  = 8,
    parameter logic [ADDR_W-1:0] XB_BASE = 12'h800,
    parameter int                TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         err,
    output logic [DATA_W-1:0]          rdata,
    output logic                       csr_sel,
    output logic                       csr_we,
    output logic [ADDR_W-1:0]          csr_addr,
    output logic [DATA_W-1:0]          csr_wdata,
    input  logic [DATA_W-1:0]          csr_rdata,
    input  logic                       csr_ack
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] NUM_REQ_L = (IDX_W+1)'(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("evo_xb_csr_arb: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 csr_sel_q, csr_sel_d;
    logic                 csr_we_q, csr_we_d;
    logic [ADDR_W-1:0]    csr_addr_q, csr_addr_d;
    logic [DATA_W-1:0]    csr_wdata_q, csr_wdata_d;

`ifdef EVO_XB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W:0]       cand;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + k[IDX_W:0];
            if (cand >= NUM_REQ_L) begin
                cand = cand - NUM_REQ_L;
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Select the winning requester's address and write data.
    always_comb begin
        win_addr  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
        win_wdata = wdata[int'(win_idx)*DATA_W +: DATA_W];
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        csr_sel_d   = csr_sel_q;
        csr_we_d    = csr_we_q;
        csr_addr_d  = csr_addr_q;
        csr_wdata_d = csr_wdata_q;
`ifdef EVO_XB_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    idx_d       = win_idx;
                    csr_addr_d  = win_addr;
                    csr_wdata_d = win_wdata;
                    if (win_addr < XB_BASE) begin
                        state_d = S_ERR;
                        err_d   = NUM_REQ'(1) << win_idx;
                    end else begin
                        state_d   = S_ACCESS;
                        csr_sel_d = 1'b1;
                        csr_we_d  = we[win_idx];
                        gnt_d     = NUM_REQ'(1) << win_idx;
`ifdef EVO_XB_ARB_TIMEOUT_EN
                        cnt_d     = CNT_W'(TIMEOUT - 1);
`endif
                    end
                end
            end
            S_ACCESS: begin
                if (csr_ack) begin
                    state_d   = S_RESP;
                    csr_sel_d = 1'b0;
                    csr_we_d  = 1'b0;
                    ack_d     = NUM_REQ'(1) << idx_q;
                    if (!csr_we_q) begin
                        rdata_d = csr_rdata;
                    end
                end
`ifdef EVO_XB_ARB_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d   = S_ERR;
                    csr_sel_d = 1'b0;
                    csr_we_d  = 1'b0;
                    gnt_d     = '0;
                    err_d     = NUM_REQ'(1) << idx_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                last_d  = idx_q;
            end
            S_ERR: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                last_d  = idx_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            csr_sel_q   <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
`ifdef EVO_XB_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            csr_sel_q   <= csr_sel_d;
            csr_we_q    <= csr_we_d;
            csr_addr_q  <= csr_addr_d;
            csr_wdata_q <= csr_wdata_d;
`ifdef EVO_XB_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign csr_sel   = csr_sel_q;
    assign csr_we    = csr_we_q;
    assign csr_addr  = csr_addr_q;
    assign csr_wdata = csr_wdata_q;

endmodule
